// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed word stream (header, payload, checksum),
// writes the payload through a registered port and releases the core only after a verified load.
module imem_loader #(
   parameter int          DEPTH  = 256,
   parameter int          ADDR_W = 8,
   parameter logic [15:0] MAGIC  = 16'h5256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [2:0] S_HDR  = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_CHK  = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   logic [2:0]        state;
   logic [ADDR_W:0]   n_words;
   logic [31:0]       sum;
   logic              accept;
   logic [16:0]       hdr_len;
   logic              hdr_bad;
   logic [ADDR_W:0]   wl_next;

   assign in_ready = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);
   assign accept   = in_valid && in_ready;
   assign core_rst = (state != S_RUN);
   assign done     = (state == S_RUN);
   assign error    = (state == S_ERR);

   // Length widened by one bit so N > DEPTH is caught even when DEPTH is 2^16.
   assign hdr_len = {1'b0, in_data[15:0]};
   assign hdr_bad = (in_data[31:16] != MAGIC) || (hdr_len == 17'd0) || (hdr_len > 17'(DEPTH));
   assign wl_next = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_HDR;
         n_words      <= '0;
         words_loaded <= '0;
         sum          <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_HDR: begin
               if (accept) begin
                  if (hdr_bad) begin
                     state <= S_ERR;
                  end else begin
                     n_words      <= hdr_len[ADDR_W:0];
                     words_loaded <= '0;
                     sum          <= '0;
                     state        <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (accept) begin
                  imem_we      <= 1'b1;
                  imem_addr    <= words_loaded[ADDR_W-1:0];
                  imem_wdata   <= in_data;
                  sum          <= sum + in_data;
                  words_loaded <= wl_next;
                  if (wl_next == n_words) state <= S_CHK;
               end
            end
            S_CHK: begin
               // The last payload write lands on this same edge, so RUN never sees stale memory.
               if (accept) state <= (in_data == sum) ? S_RUN : S_ERR;
            end
            S_RUN:   state <= S_RUN;
            S_ERR:   state <= S_ERR;
            default: state <= S_ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random frames checked against a frame-level reference model.
module tb_imem_loader;
   localparam int          DEPTH  = 256;
   localparam int          ADDR_W = 8;
   localparam logic [15:0] MAGIC  = 16'h5256;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [31:0]       in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst(core_rst), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // Behavioural memory and write statistics, sampled mid-cycle.
   logic [31:0]       tb_mem [DEPTH];
   int                we_count = 0;
   int                oob_count = 0;
   int                streak = 0;
   int                last_streak = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   int                cur_n = 0;
   logic [31:0]       pay [DEPTH];

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         tb_mem[imem_addr] = imem_wdata;
         we_count++;
         streak++;
         last_addr = imem_addr;
         if (int'(imem_addr) >= cur_n) oob_count++;
      end else begin
         if (streak != 0) last_streak = streak;
         streak = 0;
      end
   end

   function automatic bit model_hdr_ok(input logic [31:0] h);
      return (h[31:16] == MAGIC) && (h[15:0] != 16'd0) && (int'(h[15:0]) <= DEPTH);
   endfunction

   function automatic logic [31:0] model_sum(input int n);
      logic [31:0] s = 32'd0;
      for (int i = 0; i < n; i++) s = s + pay[i];
      return s;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input int gap_pct);
      bit acc = 1'b0;
      while (int'($urandom_range(99)) < gap_pct) begin
         @(negedge clk);
         in_valid = 1'b0; in_data = $urandom;
      end
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = d;
         acc = in_ready;
         @(posedge clk);
      end
      if (!acc) begin
         compared++; mismatched++;
         $display("FAIL send_word timeout: in_ready=%b required 1", in_ready);
      end
   endtask

   // Drives a whole frame; stops after the header when the header is malformed.
   task automatic send_frame(input logic [31:0] hdr, input logic [31:0] chk, input int gap_pct);
      int n = int'(hdr[15:0]);
      cur_n = model_hdr_ok(hdr) ? n : 0;
      send_word(hdr, gap_pct);
      if (model_hdr_ok(hdr)) begin
         for (int i = 0; i < n; i++) send_word(pay[i], gap_pct);
         send_word(chk, gap_pct);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      compared++;
      if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error, words_loaded} !==
          {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 9'd0}) begin
         mismatched++;
         $display("FAIL reset_values: got rdy=%b we=%b addr=%0d wd=%h crst=%b done=%b err=%b wl=%0d required 1 0 0 0 1 0 0 0",
                  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error, words_loaded);
      end
   endtask

   task automatic test_good_image();
      int base, bad;
      logic [31:0] chk;
      do_reset();
      pay[0] = 32'h00500093; pay[1] = 32'h00A00113; pay[2] = 32'h002081B3; pay[3] = 32'h0000006F;
      chk  = model_sum(4);
      base = we_count;
      send_frame(32'h52560004, chk, 0);
      compared++;
      if ({done, core_rst, error, in_ready} !== 4'b1000) begin
         mismatched++;
         $display("FAIL good_status: done/crst/err/rdy=%b%b%b%b required 1000", done, core_rst, error, in_ready);
      end
      compared++;
      if (words_loaded !== 9'd4) begin
         mismatched++; $display("FAIL good_words_loaded: got %0d required 4", words_loaded);
      end
      compared++;
      if (we_count - base != 4) begin
         mismatched++; $display("FAIL good_write_count: got %0d required 4", we_count - base);
      end
      bad = 0;
      for (int i = 0; i < 4; i++) if (tb_mem[i] !== pay[i]) bad++;
      compared++;
      if (bad != 0) begin
         mismatched++; $display("FAIL good_mem: %0d words differ, required 0", bad);
      end
   endtask

   task automatic test_bad_magic();
      int base;
      do_reset();
      base = we_count;
      cur_n = 0;
      send_word(32'h12340004, 0);
      @(negedge clk);
      in_valid = 1'b0;
      compared++;
      if ({error, in_ready, core_rst, done} !== 4'b1010) begin
         mismatched++;
         $display("FAIL bad_magic_status: err/rdy/crst/done=%b%b%b%b required 1010", error, in_ready, core_rst, done);
      end
      repeat (4) @(negedge clk);
      compared++;
      if (we_count != base || error !== 1'b1) begin
         mismatched++; $display("FAIL bad_magic_sticky: writes=%0d err=%b required 0 1", we_count - base, error);
      end
   endtask

   task automatic test_bad_checksum();
      int base;
      do_reset();
      pay[0] = 32'h00500093; pay[1] = 32'h00A00113; pay[2] = 32'h002081B3; pay[3] = 32'h0000006F;
      base = we_count;
      send_frame(32'h52560004, 32'h01508314, 0);
      compared++;
      if ({error, done, core_rst, we_count - base} !== {3'b101, 32'd4}) begin
         mismatched++;
         $display("FAIL bad_checksum: err=%b done=%b crst=%b writes=%0d required 1 0 1 4",
                  error, done, core_rst, we_count - base);
      end
   endtask

   task automatic test_bounds();
      int base, bad;
      do_reset();
      send_frame(32'h52560000, 32'd0, 0);
      compared++;
      if (error !== 1'b1 || core_rst !== 1'b1) begin
         mismatched++; $display("FAIL bounds_n0: err=%b crst=%b required 1 1", error, core_rst);
      end
      do_reset();
      send_frame({MAGIC, 16'(DEPTH + 1)}, 32'd0, 0);
      compared++;
      if (error !== 1'b1 || done !== 1'b0) begin
         mismatched++; $display("FAIL bounds_over: err=%b done=%b required 1 0", error, done);
      end
      do_reset();
      for (int i = 0; i < DEPTH; i++) pay[i] = $urandom;
      base = we_count;
      send_frame({MAGIC, 16'(DEPTH)}, model_sum(DEPTH), 0);
      @(negedge clk);
      compared++;
      if (last_streak != DEPTH || last_addr !== 8'(DEPTH - 1) || we_count - base != DEPTH) begin
         mismatched++;
         $display("FAIL bounds_full_stream: streak=%0d last_addr=%0d writes=%0d required %0d %0d %0d",
                  last_streak, last_addr, we_count - base, DEPTH, DEPTH - 1, DEPTH);
      end
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== pay[i]) bad++;
      compared++;
      if (bad != 0 || done !== 1'b1 || words_loaded !== 9'(DEPTH)) begin
         mismatched++;
         $display("FAIL bounds_full_result: bad_words=%0d done=%b wl=%0d required 0 1 %0d", bad, done, words_loaded, DEPTH);
      end
   endtask

   task automatic test_backpressure();
      int n, bad;
      logic [31:0] chk;
      n = 5 + int'($urandom_range(20));
      for (int i = 0; i < n; i++) pay[i] = $urandom;
      chk = model_sum(n);
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         for (int i = 0; i < n; i++) tb_mem[i] = ~pay[i];
         send_frame({MAGIC, 16'(n)}, chk, pass * 45);
         bad = 0;
         for (int i = 0; i < n; i++) if (tb_mem[i] !== pay[i]) bad++;
         compared++;
         if (bad != 0 || done !== 1'b1 || words_loaded !== 9'(n)) begin
            mismatched++;
            $display("FAIL backpressure_pass%0d: bad_words=%0d done=%b wl=%0d required 0 1 %0d",
                     pass, bad, done, words_loaded, n);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      int base, bad;
      do_reset();
      cur_n = 4;
      send_word(32'h52560004, 0);
      send_word(32'hAAAA0000, 0);
      send_word(32'hAAAA0001, 0);
      do_reset();
      compared++;
      if ({words_loaded, done, error, core_rst, in_ready} !== {9'd0, 4'b0011}) begin
         mismatched++;
         $display("FAIL midload_reset: wl=%0d done=%b err=%b crst=%b rdy=%b required 0 0 0 1 1",
                  words_loaded, done, error, core_rst, in_ready);
      end
      for (int i = 0; i < 4; i++) pay[i] = 32'hB000_0000 + 32'(i) * 32'h11;
      base = we_count;
      send_frame(32'h52560004, model_sum(4), 20);
      bad = 0;
      for (int i = 0; i < 4; i++) if (tb_mem[i] !== pay[i]) bad++;
      compared++;
      if (bad != 0 || we_count - base != 4 || done !== 1'b1 || words_loaded !== 9'd4) begin
         mismatched++;
         $display("FAIL midload_second_frame: bad_words=%0d writes=%0d done=%b wl=%0d required 0 4 1 4",
                  bad, we_count - base, done, words_loaded);
      end
   endtask

   task automatic test_random_frames();
      int n, mode, base, bad, exp_n;
      logic [31:0] hdr, chk;
      bit exp_ok, exp_done;
      for (int f = 0; f < 10; f++) begin
         do_reset();
         mode = int'($urandom_range(4));
         n    = 1 + int'($urandom_range(40));
         for (int i = 0; i < n; i++) pay[i] = $urandom;
         hdr = {MAGIC, 16'(n)};
         chk = model_sum(n);
         case (mode)
            1: chk = chk ^ (32'd1 << $urandom_range(31));
            2: hdr[31:16] = MAGIC ^ 16'(1 + $urandom_range(65534));
            3: hdr[15:0] = 16'(DEPTH + 1 + int'($urandom_range(1000)));
            default: ;
         endcase
         exp_ok   = model_hdr_ok(hdr);
         exp_done = exp_ok && (chk == model_sum(n));
         exp_n    = exp_ok ? n : 0;
         base = oob_count;
         bad  = we_count;
         send_frame(hdr, chk, 30);
         repeat (2) @(negedge clk);
         compared++;
         if ({done, error, core_rst, in_ready, words_loaded} !== {exp_done, !exp_done, !exp_done, 1'b0, 9'(exp_n)}) begin
            mismatched++;
            $display("FAIL random_frame%0d_status: done=%b err=%b crst=%b rdy=%b wl=%0d required %b %b %b 0 %0d",
                     f, done, error, core_rst, in_ready, words_loaded, exp_done, !exp_done, !exp_done, exp_n);
         end
         compared++;
         if (we_count - bad != exp_n || oob_count != base) begin
            mismatched++;
            $display("FAIL random_frame%0d_writes: writes=%0d oob=%0d required %0d 0",
                     f, we_count - bad, oob_count - base, exp_n);
         end
         bad = 0;
         for (int i = 0; i < exp_n; i++) if (tb_mem[i] !== pay[i]) bad++;
         compared++;
         if (bad != 0) begin
            mismatched++; $display("FAIL random_frame%0d_mem: %0d words differ, required 0", f, bad);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      test_reset();
      test_good_image();
      test_bad_magic();
      test_bad_checksum();
      test_bounds();
      test_backpressure();
      test_reset_mid_load();
      test_random_frames();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
